// File: rtl/ram_burst_pkg.sv
// Shared state encoding and default widths for the RAM burst sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ram_burst_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_READ  = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LEN_W      = 8;
  localparam int DEF_RBUF_DEPTH = 4;

endpackage

// File: rtl/ram_rd_fifo.sv
// Synchronous FIFO holding returned read words (data plus last tag).
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller bounds pushes by the occupancy output.
module ram_rd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next pointers and occupancy; a push into a full FIFO only lands alongside a pop.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/ram_burst_ctrl.sv
// Expands read/write burst commands into per-word RAM strobes with incrementing addresses.
// Latency: first write strobe 1 cycle after command accept; first read word valid 3 cycles after.
// Backpressure: cmd held while busy; wdata_ready follows wdata_valid; reads stall once buffer+in-flight reach RBUF_DEPTH.
module ram_burst_ctrl
  import ram_burst_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int RBUF_DEPTH = DEF_RBUF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic              busy,
  output logic              done
);

  localparam int OCC_W = $clog2(RBUF_DEPTH + 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              infl_q, infl_d;
  logic              infl_last_q, infl_last_d;
  logic              done_q, done_d;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W:0]    outstanding;
  logic [DATA_W:0]   head;
  logic              head_last;
  logic              rd_pop;

  // Read buffer: the word requested last cycle arrives now and is pushed with its last tag.
  ram_rd_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (RBUF_DEPTH)
  ) u_rd_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (infl_q),
    .push_dat ({infl_last_q, ram_read_data}),
    .pop      (rd_pop),
    .head_dat (head),
    .count    (occ)
  );

  // Read-stream outputs from the buffer head, zeroed while empty.
  always_comb begin
    rdata_valid = (occ != '0);
    head_last   = head[DATA_W];
    rdata       = rdata_valid ? head[DATA_W-1:0] : '0;
    rdata_last  = rdata_valid & head_last;
    rd_pop      = rdata_valid & rdata_ready;
    outstanding = {1'b0, occ} + {{OCC_W{1'b0}}, infl_q};
  end

  // Burst sequencing: command accept, per-word strobes, and completion detection.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    infl_d      = 1'b0;
    infl_last_d = 1'b0;
    cmd_ready   = (state_q == ST_IDLE);
    wdata_ready = 1'b0;
    ram_write   = 1'b0;
    ram_read    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        wdata_ready = wdata_valid;
        ram_write   = wdata_valid;
        if (wdata_valid) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - LEN_W'(1);
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_READ: begin
        // Never request more than the buffer can hold, counting the word still in flight.
        ram_read = (outstanding < (OCC_W + 1)'(RBUF_DEPTH));
        if (ram_read) begin
          addr_d      = addr_q + ADDR_W'(1);
          cnt_d       = cnt_q - LEN_W'(1);
          infl_d      = 1'b1;
          infl_last_d = (cnt_q == '0);
          if (cnt_q == '0) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (rd_pop && head_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM-side address/data; the address holds its last strobed value between strobes.
  always_comb begin
    ram_address = (ram_read | ram_write) ? addr_q : ram_addr_q;
    ram_addr_d  = ram_address;
    ram_data    = (state_q == ST_WRITE) ? wdata : '0;
    busy        = (state_q != ST_IDLE);
    done        = done_q;
  end

  // Control registers; reset abandons any burst and drops the word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
      ram_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
      ram_addr_q  <= ram_addr_d;
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Testbench for ram_burst_ctrl: a behavioural RAM plus a reference memory feeding scoreboards.
// Expected writes and read words are queued at command issue; a negedge monitor pops and compares.
// Directed scenarios cover timing and boundaries, then a randomized burst mix follows.
module tb_ram_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid, rdata_ready, rdata_last;
  logic [31:0] rdata;
  logic        ram_read, ram_write;
  logic [31:0] ram_address, ram_data;
  logic [31:0] ram_read_data = 32'h0;
  logic        busy, done;

  always #5 clk = ~clk;

  ram_burst_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .wdata_valid   (wdata_valid),
    .wdata_ready   (wdata_ready),
    .wdata         (wdata),
    .rdata_valid   (rdata_valid),
    .rdata_ready   (rdata_ready),
    .rdata         (rdata),
    .rdata_last    (rdata_last),
    .ram_read      (ram_read),
    .ram_write     (ram_write),
    .ram_address   (ram_address),
    .ram_data      (ram_data),
    .ram_read_data (ram_read_data),
    .busy          (busy),
    .done          (done)
  );

  // Behavioural RAM: writes land at the edge, read data is registered.
  logic [31:0] ram_mem [logic [31:0]];
  always @(posedge clk) begin
    if (ram_read) ram_read_data <= ram_mem.exists(ram_address) ? ram_mem[ram_address] : 32'h0;
    if (ram_write) ram_mem[ram_address] = ram_data;
  end

  // Reference model and scoreboard state.
  logic [31:0] ref_mem [logic [31:0]];
  logic [63:0] exp_wr [$];
  logic [32:0] exp_rd [$];
  logic [31:0] wwords [$];
  logic [63:0] ew;
  logic [32:0] er;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;
  bit mon_en = 1'b0;
  bit have_prev = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  int wr_cnt, first_wr, last_wr, rd_issues, first_rv, first_rhs, last_rhs, rhs_cnt;
  int done_cyc = -1;
  int done_cnt = 0;
  bit busy_at_done, rdy_at_done;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic clr_stats();
    wr_cnt = 0; first_wr = -1; last_wr = -1; rd_issues = 0;
    first_rv = -1; first_rhs = -1; last_rhs = -1; rhs_cnt = 0;
  endtask

  // Monitor: scoreboard compares on every strobe and every read handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rw_mutex", 64'(ram_read & ram_write), 64'd0);
      if (ram_write) begin
        chk("wr_pending", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) begin
          ew = exp_wr.pop_front();
          chk("wr_addr", 64'(ram_address), 64'(ew[63:32]));
          chk("wr_data", 64'(ram_data), 64'(ew[31:0]));
        end
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        wr_cnt++;
      end
      if (ram_read) rd_issues++;
      if (ram_read | ram_write) begin
        prev_addr = ram_address;
        have_prev = 1'b1;
      end else if (have_prev) begin
        chk("addr_hold", 64'(ram_address), 64'(prev_addr));
      end
      if (rdata_valid && first_rv < 0) first_rv = cyc;
      if (rdata_valid && rdata_ready) begin
        chk("rd_pending", 64'(exp_rd.size() != 0), 64'd1);
        if (exp_rd.size() != 0) begin
          er = exp_rd.pop_front();
          chk("rdata", 64'(rdata), 64'(er[31:0]));
          chk("rdata_last", 64'(rdata_last), 64'(er[32]));
        end
        if (first_rhs < 0) first_rhs = cyc;
        last_rhs = cyc;
        rhs_cnt++;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
      rdy_at_done = cmd_ready;
    end
  end

  // Read-side sink: always ready, random, or stalled.
  initial begin
    rdata_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: rdata_ready = 1'b1;
        1: rdata_ready = 1'($urandom_range(0, 1));
        default: rdata_ready = 1'b0;
      endcase
    end
  end

  // Issue one command (call just after a rising edge); the model is updated at issue.
  task automatic issue_cmd(input bit w, input logic [31:0] a, input int l, input bit seq, output int h);
    bit got = 1'b0;
    logic [31:0] aa, d;
    for (int i = 0; i <= l; i++) begin
      aa = a + 32'(i);
      if (w) begin
        d = seq ? 32'(i + 1) : $urandom;
        wwords.push_back(d);
        exp_wr.push_back({aa, d});
        ref_mem[aa] = d;
      end else begin
        exp_rd.push_back({(i == l), ref_get(aa)});
      end
    end
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = 8'(l);
    h = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1'b1; break; end
    end
    chk("cmd_accept_timeout", 64'(got), 64'd1);
    h = cyc + 1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Feed write data: mode 0 continuous, 1 alternating, 2 random gaps.
  task automatic send_wdata(input int l, input int mode);
    int i = 0;
    int k = 0;
    bit acc;
    while (i <= l && k < 2000) begin
      wdata = wwords[0];
      case (mode)
        0: wdata_valid = 1'b1;
        1: wdata_valid = (k % 2 == 0);
        default: wdata_valid = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      chk("wdata_ready_eq_valid", 64'(wdata_ready), 64'(wdata_valid));
      chk("ram_write_eq_valid", 64'(ram_write), 64'(wdata_valid));
      acc = wdata_valid & wdata_ready;
      @(posedge clk); #1;
      if (acc) begin
        void'(wwords.pop_front());
        i++;
      end
      k++;
    end
    chk("wdata_all_sent", 64'(i), 64'(l + 1));
    wdata_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    chk("done_timeout", 64'(got), 64'd1);
    if (got) begin
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, cycle=%0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h, h2, dc;
    logic [31:0] base;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0;
    clr_stats();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wdata_ready", 64'(wdata_ready), 64'd0);
    chk("rst_ram_strobes", 64'({ram_read, ram_write}), 64'd0);
    chk("rst_rdata_valid", 64'(rdata_valid), 64'd0);
    chk("rst_rdata_last", 64'(rdata_last), 64'd0);
    chk("rst_ram_address", 64'(ram_address), 64'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Write burst 0x10, 4 words 1..4, continuous.
    clr_stats();
    issue_cmd(1'b1, 32'h10, 3, 1'b1, h);
    send_wdata(3, 0);
    wait_done(50);
    chk("wr_first_cycle", 64'(first_wr), 64'(h));
    chk("wr_last_cycle", 64'(last_wr), 64'(h + 3));
    chk("wr_count", 64'(wr_cnt), 64'd4);
    chk("wr_done_cycle", 64'(done_cyc), 64'(last_wr + 1));
    chk("wr_busy_at_done", 64'(busy_at_done), 64'd0);
    chk("wr_cmd_ready_at_done", 64'(rdy_at_done), 64'd1);

    // Read-back 0x10, 4 words, sink always ready.
    clr_stats();
    issue_cmd(1'b0, 32'h10, 3, 1'b0, h);
    wait_done(100);
    chk("rd_first_valid", 64'(first_rv), 64'(h + 2));
    chk("rd_first_hs", 64'(first_rhs), 64'(h + 2));
    chk("rd_last_hs", 64'(last_rhs), 64'(h + 5));
    chk("rd_hs_count", 64'(rhs_cnt), 64'd4);
    chk("rd_done_cycle", 64'(done_cyc), 64'(last_rhs + 1));

    // Back-pressure: 8-word read with the sink stalled for 6 cycles.
    issue_cmd(1'b1, 32'h100, 7, 1'b0, h);
    send_wdata(7, 2);
    wait_done(100);
    rdy_mode = 2;
    @(posedge clk); #1;
    clr_stats();
    issue_cmd(1'b0, 32'h100, 7, 1'b0, h);
    repeat (6) @(negedge clk);
    chk("bp_read_issues", 64'(rd_issues), 64'd4);
    chk("bp_ram_read_low", 64'(ram_read), 64'd0);
    chk("bp_rdata_valid", 64'(rdata_valid), 64'd1);
    @(posedge clk); #1;
    rdy_mode = 0;
    wait_done(100);
    chk("bp_hs_count", 64'(rhs_cnt), 64'd8);
    chk("bp_queue_empty", 64'(exp_rd.size()), 64'd0);

    // Address wrap at the top of the space, then read back across it.
    issue_cmd(1'b1, 32'hFFFF_FFFE, 2, 1'b0, h);
    send_wdata(2, 0);
    wait_done(50);
    issue_cmd(1'b0, 32'hFFFF_FFFE, 2, 1'b0, h);
    wait_done(100);

    // Write-data gaps, with a second command held during the burst.
    clr_stats();
    issue_cmd(1'b1, 32'h300, 2, 1'b0, h);
    fork
      send_wdata(2, 1);
      issue_cmd(1'b0, 32'h300, 2, 1'b0, h2);
    join
    chk("gap_wr_count", 64'(wr_cnt), 64'd3);
    chk("gap_first_wr", 64'(first_wr), 64'(h));
    chk("gap_last_wr", 64'(last_wr), 64'(h + 4));
    chk("busy_cmd_accept", 64'(h2), 64'(done_cyc + 1));
    wait_done(100);

    // Reset mid-read with two words buffered.
    issue_cmd(1'b1, 32'h400, 3, 1'b0, h);
    send_wdata(3, 0);
    wait_done(50);
    rdy_mode = 2;
    @(posedge clk); #1;
    issue_cmd(1'b0, 32'h400, 3, 1'b0, h);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_rd.delete();
    have_prev = 1'b0;
    dc = done_cnt;
    @(negedge clk);
    chk("mid_rst_rdata_valid", 64'(rdata_valid), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("mid_rst_late_data_dropped", 64'(rdata_valid), 64'd0);
    chk("mid_rst_no_done", 64'(done_cnt), 64'(dc));
    @(posedge clk); #1;
    mon_en = 1'b1;
    rdy_mode = 0;
    issue_cmd(1'b0, 32'h400, 3, 1'b0, h);
    wait_done(100);

    // Randomized burst mix.
    for (int t = 0; t < 30; t++) begin
      int l;
      bit w;
      case ($urandom_range(0, 2))
        0: base = 32'h200;
        1: base = 32'h240;
        default: base = 32'hFFFF_FFF8;
      endcase
      w = 1'($urandom_range(0, 1));
      l = $urandom_range(0, 15);
      rdy_mode = $urandom_range(0, 1);
      issue_cmd(w, base + 32'($urandom_range(0, 15)), l, 1'b0, h);
      if (w) send_wdata(l, $urandom_range(0, 2));
      wait_done(600);
    end
    rdy_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("final_wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    chk("final_rd_queue_empty", 64'(exp_rd.size()), 64'd0);
    chk("final_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Burst sequencer sitting directly upstream of the `ram` block. It accepts one read or write burst command at a time over a valid/ready handshake and expands it into per-word `read`/`write` strobes with incrementing word addresses. It streams write data in and read data out over valid/ready channels. A small read buffer absorbs the RAM's one-cycle read latency so that downstream back-pressure never loses data.

## Interface
Parameters:
- `ADDR_W`, default 32: word-address width, matching the `ram` address port.
- `DATA_W`, default 32: data width, matching the `ram` data ports.
- `LEN_W`, default 8: burst-length field width.
- `RBUF_DEPTH`, default 4: read-buffer entries; minimum 3 for full read throughput.

Ports (one clock `clk`; `reset` is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when high with `cmd_valid`.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in ADDR_W: first word address.
- `cmd_len` in LEN_W: burst length minus 1 (0 → 1 word, max → 2^LEN_W words).
- `wdata_valid` in 1 / `wdata_ready` out 1 / `wdata` in DATA_W: write-data stream.
- `rdata_valid` out 1 / `rdata_ready` in 1 / `rdata` out DATA_W / `rdata_last` out 1: read-data stream.
- `ram_read` out 1, `ram_write` out 1, `ram_address` out ADDR_W, `ram_data` out DATA_W: drive `ram` ports `read`, `write`, `address`, `data`.
- `ram_read_data` in DATA_W: from `ram` `read_data`. It is registered by `ram` and valid the cycle after `read` is sampled.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse at burst completion.

## Operation
- **States:** IDLE, WRITE, READ, DRAIN.
- **IDLE:** `cmd_ready`=1. On a handshake, latch the address and the remaining count (`cmd_len`), then go to WRITE or READ per `cmd_write`.
- **WRITE:**
  - `wdata_ready` = `ram_write` = `wdata_valid`.
  - `ram_data` = `wdata`; `ram_address` = address counter.
  - Each accepted word increments the address and decrements the count.
  - After the word with count 0, go to IDLE and pulse `done`.
- **READ:**
  - `ram_read` = (buffer occupancy + in-flight reads < RBUF_DEPTH).
  - Each issued read increments the address and decrements the count. After the read with count 0, go to DRAIN.
  - The in-flight read's `ram_read_data` is pushed into the buffer the next cycle, tagged last if it was the final word.
- **DRAIN:** no RAM activity. When the last-tagged entry is handshaken on `rdata`, go to IDLE and pulse `done`.
- **Read buffer:** `rdata`/`rdata_last` = head entry; `rdata_valid` = buffer not empty. Pop on `rdata_valid & rdata_ready`. Push and pop may occur in the same cycle.
- **Address wrap:** the address increments modulo 2^ADDR_W (`{ADDR_W{1}}` → 0); burst length is unaffected.
- **Commands while busy:** `cmd_ready`=0, so the command is not accepted and is held by the source.
- **Mutual exclusion:** `ram_read` and `ram_write` are never high in the same cycle. `ram_address` holds its value when no strobe is active.
- **Reset values:** state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `wdata_ready`=0, `ram_read`=0, `ram_write`=0, `rdata_valid`=0, `rdata_last`=0, buffer empty, in-flight count 0. `ram_address`, `ram_data` and `rdata` are don't-care but driven to 0.
- **Reset mid-burst:** the burst is abandoned and the buffer is flushed. Read data returning the cycle after reset is discarded. `done` is not pulsed.

## Timing
- **Write burst:** handshake at edge E0; `ram_write` from cycle E0+1. N words take N cycles when `wdata_valid` is held high. `done` is high in the cycle after the last write edge, with `cmd_ready` already 1.
- **Read burst:** handshake at E0; `ram_read` in cycle E0+1; data captured into the buffer at E0+3; `rdata_valid` from cycle E0+3.
- **Read throughput:** with `rdata_ready` held high and RBUF_DEPTH ≥ 3, one word per cycle.
- **`done` timing:** high in the cycle after the last `rdata` handshake.
- **Back-pressure bound:** with `rdata_ready` low, at most RBUF_DEPTH reads are outstanding (buffered plus in-flight), then `ram_read` drops.

## Structure
- Package `ram_burst_pkg`: state enum (IDLE/WRITE/READ/DRAIN) and default-width constants.
- Sub-module `ram_rd_fifo`: a synchronous FIFO of DATA_W+1 bits (data + last), RBUF_DEPTH entries, with occupancy output and the same `clk`/`reset`.

## Test plan
- **Write burst:** write `cmd_addr`=0x10, `cmd_len`=3, `wdata` 0x1..0x4 continuous → `ram_write` high 4 consecutive cycles at addresses 0x10..0x13, `done` one cycle after, `busy` low.
- **Read-back:** read 0x10, len 3, `rdata_ready`=1 → `rdata` 0x1,0x2,0x3,0x4 on consecutive cycles, first `rdata_valid` at E0+3, `rdata_last` only on 0x4, then `done`.
- **Back-pressure:** read len 7 with `rdata_ready` low for 6 cycles → `ram_read` stops after 4 issues. On release, all 8 words arrive in order with none lost or duplicated.
- **Address wrap:** write at 0xFFFFFFFE, len 2 → `ram_address` sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0.
- **Write-data gaps and busy commands:** `wdata_valid` toggled 1,0,1,0,1 during a 3-word write → exactly 3 `ram_write` pulses, aligned with `wdata_valid`. A second `cmd_valid` asserted during the burst is accepted only after `done`.
- **Reset mid-read:** reset for 1 cycle mid-read with 2 words buffered → next cycle `rdata_valid`=0, `cmd_ready`=1, no `done`. A subsequent read returns correct data.
